cla_nibble_serial_adder: RTL and testbench
==========================================

CLA_NIBBLE_SERIAL_ADDER -- requirements
Module: cla_nibble_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4, minimum 4; NIBBLES = WIDTH/4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set present on a, b, cin.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  carry into bit 0.
REQ-009 out_valid  output  1  sum and cout hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result bits, (a + b + cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 Datapath SHALL be one 4-bit carry-lookahead slice: generate g_i = a_i & b_i, propagate p_i = a_i ^ b_i, c_(i+1) = g_i | p_i & c_i, flattened to two-level form per bit, s_i = p_i ^ c_i.
REQ-014 FSM states SHALL be IDLE, RUN, DONE, with in_ready = (state == IDLE) and out_valid = (state == DONE).
REQ-015 IDLE: on in_valid & in_ready, SHALL register a, b, cin into op_a, op_b, carry; clear nibble index idx to 0; go to RUN.
REQ-016 RUN: each cycle SHALL add nibble idx of op_a/op_b with carry, write the 4 sum bits into sum[4*idx+3:4*idx], load the slice carry-out into carry, increment idx.
REQ-017 RUN -> DONE on the edge that processes idx = NIBBLES-1; cout SHALL take that slice's carry-out on the same edge.
REQ-018 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting edge (4 cycles for WIDTH=16).
REQ-019 DONE: sum and cout SHALL remain stable until out_valid & out_ready; then go to IDLE.
REQ-020 in_valid during RUN or DONE SHALL be ignored; a, b, cin changes after acceptance SHALL not affect the result.
REQ-021 Minimum initiation interval SHALL be NIBBLES+2 cycles (accept, NIBBLES RUN edges, DONE handshake, back to IDLE).
REQ-022 WIDTH=4 SHALL give a single RUN cycle and function identically otherwise.
REQ-023 Unused sum nibbles from a prior operation SHALL be overwritten before out_valid; no stale bits visible in DONE.

Reset
REQ-024 rst high at a clock edge SHALL force state IDLE, idx 0, carry 0, sum 0, cout 0, out_valid 0, in_ready 1 after that edge.
REQ-025 rst SHALL take priority over any handshake on the same edge; an operation in RUN or DONE SHALL be discarded with no out_valid.
REQ-026 in_ready SHALL be 0 only while rst is low and state is RUN or DONE; first acceptance possible on the first edge with rst low.

Configuration
REQ-027 Macro CLA_SERIAL_OVF_EN: when defined, SHALL add output ovf (1 bit), registered with cout, = signed two's-complement overflow = carry into bit WIDTH-1 XOR cout, reset 0, stable in DONE.
REQ-028 Without CLA_SERIAL_OVF_EN, ovf port and logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16)
REQ-029 Reset: assert rst mid-RUN with a=16'h1234 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0; no result emitted.
REQ-030 Basic: a=16'h1234, b=16'h4321, cin=0 accepted at T -> out_valid at T+4, sum=16'h5555, cout=0.
REQ-031 Full ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1; a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
REQ-032 Backpressure: out_ready held 0 for 10 cycles in DONE, in_valid toggling with new operands -> sum/cout unchanged, in_ready=0 throughout, exactly one result on release.
REQ-033 Back-to-back: in_valid and out_ready tied high, 1000 random operand pairs -> each result matches a+b+cin, issue spacing 6 cycles.
REQ-034 With CLA_SERIAL_OVF_EN: a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; a=16'h8000, b=16'h8000 -> sum=0, cout=1, ovf=1.

Source files
------------

// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused over WIDTH/4 cycles.
// Optional signed-overflow output enabled by defining CLA_SERIAL_OVF_EN.
module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [WIDTH-1:0] op_a, op_a_d;
    logic [WIDTH-1:0] op_b, op_b_d;
    logic             carry, carry_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf_d;
`endif

    logic [3:0] nib_a, nib_b, g, p, s;
    logic [4:0] c;

    // Carry-lookahead slice on the current nibble, carries flattened to sum-of-products
    always_comb begin
        nib_a = op_a[4*idx +: 4];
        nib_b = op_b[4*idx +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s     = p ^ c[3:0];
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state;
        idx_d   = idx;
        op_a_d  = op_a;
        op_b_d  = op_b;
        carry_d = carry;
        sum_d   = sum;
        cout_d  = cout;
`ifdef CLA_SERIAL_OVF_EN
        ovf_d   = ovf;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx +: 4] = s;
                carry_d           = c[4];
                if (idx == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = c[4];
`ifdef CLA_SERIAL_OVF_EN
                    ovf_d   = c[3] ^ c[4];
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            idx   <= idx_d;
            op_a  <= op_a_d;
            op_b  <= op_b_d;
            carry <= carry_d;
            sum   <= sum_d;
            cout  <= cout_d;
`ifdef CLA_SERIAL_OVF_EN
            ovf   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Randomized self-checking bench for cla_nibble_serial_adder (WIDTH=16) against
// an arithmetic scoreboard; ovf is checked when CLA_SERIAL_OVF_EN is defined.
module tb_cla_nibble_serial_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_SERIAL_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_SERIAL_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [31:0]  t;
    } op_t;

    op_t         q[$];
    op_t         e;
    logic [W:0]  ref_v;
    int unsigned ncyc     = 0;
    int unsigned last_acc = 0;
    bit          have_last = 1'b0;
    bit          b2b      = 1'b0;
    int          results  = 0;
    int          accepts  = 0;
    int          dropped  = 0;

    // Scoreboard: handshakes observed mid-cycle take effect on the following edge
    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            dropped += q.size();
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e     = q.pop_front();
                    ref_v = {1'b0, e.a} + {1'b0, e.b} + (W+1)'(e.cin);
                    check("sb_sum", sum, ref_v[W-1:0]);
                    check("sb_cout", cout, ref_v[W]);
`ifdef CLA_SERIAL_OVF_EN
                    check("sb_ovf", ovf, (e.a[W-1] == e.b[W-1]) && (ref_v[W-1] != e.a[W-1]));
`endif
                    // accept edge follows sample t; DONE is seen one sample after the 4th RUN edge
                    if (b2b) check("sb_latency", ncyc - e.t, 4 + 1);
                    results++;
                end
            end
            if (in_valid && in_ready) begin
                if (b2b && have_last) check("issue_spacing", ncyc - last_acc, 6);
                last_acc  = ncyc;
                have_last = 1'b1;
                q.push_back('{a: a, b: b, cin: cin, t: ncyc});
                accepts++;
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec);
        int n;
        check("ready_before_op", in_ready, 1);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 4);
        check("op_sum", sum, es);
        check("op_cout", cout, ec);
        @(posedge clk); #1;
        check("ready_after_op", in_ready, 1);
        check("valid_after_op", out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, s0;
        logic         rc;
        logic [W:0]   r;
        int           r0, n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst = 1'b0;

        // Reset in the middle of RUN discards the operation
        a        = 16'h1234;
        b        = 16'h4321;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_run_busy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        rst = 1'b0;
        r0 = results;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_result", results, r0);
        check("midrst_no_valid", out_valid, 0);

        // Directed operands
        do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        do_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            r  = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            do_op(ra, rb, rc, r[W-1:0], r[W]);
        end

        // Backpressure in DONE with in_valid toggling
        out_ready = 1'b0;
        a         = 16'hABCD;
        b         = 16'h1357;
        cin       = 1'b1;
        r         = {1'b0, 16'hABCD} + {1'b0, 16'h1357} + 17'd1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_latency", n, 4);
        r0 = results;
        s0 = r[W-1:0];
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            @(posedge clk); #1;
            check("bp_sum", sum, s0);
            check("bp_cout", cout, r[W]);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_one_result", results, r0 + 1);
        check("bp_released", out_valid, 0);
        check("bp_ready_back", in_ready, 1);

        // Back-to-back with in_valid/out_ready tied high; operands change every cycle
        b2b       = 1'b1;
        have_last = 1'b0;
        r0        = results;
        in_valid  = 1'b1;
        n         = 0;
        while ((results - r0) < 1000 && n < 8000) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("b2b_count_reached", (results - r0) >= 1000, 1);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
        check("result_count", results, accepts - dropped);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
